// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared fetch-PC defaults, next-PC source encoding and group-size helpers.
package pc_gen_pkg;
  localparam int          ADDR_W_DEF     = 32;
  localparam int          FETCH_W_DEF    = 1;
  localparam logic [31:0] RESET_ADDR_DEF = 32'hBFC0_0000;
  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_EXC,
    SRC_PEND,
    SRC_BR,
    SRC_SEQ
  } pc_src_e;
  function automatic int grp_bytes(input int fw);
    return fw * 4;
  endfunction
  function automatic int grp_bits(input int fw);
    return $clog2(fw * 4);
  endfunction
endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: holds one branch redirect that arrived while IF was stalled; the oldest branch wins.
module pc_redirect_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall,
  input  logic              exc_req,
  input  logic              br_req,
  input  logic [ADDR_W-1:0] br_target,
  output logic              pend_v,
  output logic [ADDR_W-1:0] pend_tgt
);
  logic              r_v;
  logic [ADDR_W-1:0] r_tgt;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_v   <= 1'b0;
      r_tgt <= '0;
    end else if (exc_req) begin
      r_v <= 1'b0;
    end else if (stall) begin
      if (br_req && !r_v) begin
        r_v   <= 1'b1;
        r_tgt <= br_target;
      end
    end else begin
      r_v <= 1'b0;
    end
  end
  assign pend_v   = r_v;
  assign pend_tgt = r_tgt;
endmodule

// File: rtl/pc_gen.sv
// pc_gen: IF-stage fetch-PC register with exception/branch/sequential next-PC selection,
// per-slot valid mask for a FETCH_W-wide group, and fetch-address alignment error.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                FETCH_W    = FETCH_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_ADDR_DEF)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               stall,
  input  logic               exc_req,
  input  logic [ADDR_W-1:0]  exc_target,
  input  logic               br_req,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               fetch_valid,
  output logic [FETCH_W-1:0] slot_mask,
  output logic               redirect_o,
  output logic               addr_err
);
  localparam int GRP = grp_bytes(FETCH_W);
  localparam int GB  = grp_bits(FETCH_W);
  logic [ADDR_W-1:0] r_pc;
  logic              r_fv;
  logic              r_red;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_pend_tgt;
  logic              w_pend_v;
  logic              w_red_nxt;
  pc_src_e           w_src;
  pc_redirect_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clk       (clk),
    .resetn    (resetn),
    .stall     (stall),
    .exc_req   (exc_req),
    .br_req    (br_req),
    .br_target (br_target),
    .pend_v    (w_pend_v),
    .pend_tgt  (w_pend_tgt)
  );
  // Sequential step always lands on the next group boundary, realigning a misaligned pc.
  assign w_seq = (r_pc & ~ADDR_W'(GRP - 1)) + ADDR_W'(GRP);
  always_comb begin
    w_src     = exc_req ? SRC_EXC : stall ? SRC_HOLD : w_pend_v ? SRC_PEND : br_req ? SRC_BR : SRC_SEQ;
    w_pc_nxt  = w_src == SRC_EXC  ? exc_target :
                w_src == SRC_PEND ? w_pend_tgt :
                w_src == SRC_BR   ? br_target  :
                w_src == SRC_SEQ  ? w_seq      : r_pc;
    w_red_nxt = w_src == SRC_EXC || w_src == SRC_PEND || w_src == SRC_BR;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc  <= RESET_ADDR;
      r_fv  <= 1'b0;
      r_red <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_fv  <= 1'b1;
      r_red <= w_red_nxt;
    end
  end
  assign pc_o        = r_pc;
  assign fetch_valid = r_fv;
  assign redirect_o  = r_red;
  assign addr_err    = |r_pc[1:0];
  generate
    if (FETCH_W == 1) begin : g_single
      assign slot_mask = 1'b1;
    end else begin : g_multi
      localparam int OW = GB - 2;
      logic [OW-1:0] w_off;
      assign w_off = r_pc[GB-1:2];
      for (genvar i = 0; i < FETCH_W; i++) begin : g_slot
        assign slot_mask[i] = OW'(i) >= w_off;
      end
    end
  endgenerate
endmodule
